proc_phase_sequencer: RTL and testbench
=======================================

Name: proc_phase_sequencer

Overview:
- Parametrised phase/strobe sequencer for the multicycle MIPS core.
- Derives one-hot phase enables from the single system clock, replacing per-unit derived clocks (imem, regfile, processor/dmem, PC).
- Phase mapping with NUM_PHASES=4: phase 0 = imem fetch, 1 = regfile read, 2 = ALU/dmem, 3 = regfile write/PC update.
- Adds a core-reset stretcher, run/halt/single-step control, and cycle/instruction counters for bench instrumentation.

Parameters:
- NUM_PHASES, 4, phases per instruction (≥2).
- PH_W, 2, width of phase_idx (≥ clog2(NUM_PHASES)).
- RESET_HOLD, 2, cycles core_reset stays high after reset deasserts (0 allowed).
- CYC_W, 32, width of the cycle and instruction counters.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- run_en  in  1  level; free-run when high.
- step_req  in  1  single-step request; rising edge detected internally.
- halt_req  in  1  level; halt at the next instruction boundary.
- phase_en  out  NUM_PHASES  one-hot phase strobe; all zero when idle.
- phase_idx  out  PH_W  current phase number.
- instr_done  out  1  high during the last phase of each instruction (PC update strobe).
- core_reset  out  1  stretched reset to the core.
- halted  out  1  high in HALT state.
- cycle_count  out  CYC_W  cycles with any phase_en bit high.
- instr_count  out  CYC_W  completed instructions.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. All outputs are registered (Moore).
- Reset values: state=RESET, phase_en=0, phase_idx=0, instr_done=0, core_reset=1, halted=0, both counters=0, step edge register=0.
- RESET state:
  - core_reset held 1 for RESET_HOLD cycles after reset drops.
  - Then core_reset=0 and the FSM goes to RUN if run_en=1 and halt_req=0, else HALT.
  - RESET_HOLD=0: exit on the first edge after reset drops.
- RUN state:
  - phase_en = 1<<phase_idx every cycle.
  - phase_idx increments, wrapping from NUM_PHASES-1 to 0.
  - instr_done=1 only when phase_idx=NUM_PHASES-1.
  - At that boundary cycle: if halt_req=1 or run_en=0, the next state is HALT. The instruction always completes; no mid-instruction halt.
- HALT state:
  - phase_en=0, phase_idx=0, halted=1.
  - Next state is RUN if run_en=1 and halt_req=0.
  - Otherwise, a step_req rising edge moves to STEP.
  - halt_req=1 suppresses step; run wins over a simultaneous step, and that step edge is discarded.
- STEP state:
  - Executes exactly NUM_PHASES cycles, identical to RUN, then returns to HALT.
  - run_en, halt_req and step_req are ignored until the boundary.
- Latency:
  - HALT to first phase_en[0]: 1 cycle after the edge sampling run_en=1 (or the step edge).
  - Boundary to halted=1: next cycle.
- Counters:
  - cycle_count increments in every cycle where phase_en≠0.
  - instr_count increments on every cycle where instr_done=1.
  - Both saturate at all-ones; no wrap.
- Reset mid-instruction: the instruction is aborted; all outputs return to reset values on that edge, and counters clear.
- Step edge detection is active in all states. An edge arriving outside HALT is dropped, not queued.

Optional Feature:
- Macro: PROC_PHASE_STALL_EN.
- Defined:
  - Adds parameter STALL_PHASE (default 2) and input mem_stall (1 bit).
  - In RUN/STEP, when phase_idx=STALL_PHASE and mem_stall=1: phase_idx holds and phase_en re-asserts the same bit each stalled cycle.
  - cycle_count still increments; instr_done is unaffected.
  - The phase advances on the first cycle mem_stall=0.
- Undefined: no mem_stall port; phases always advance every cycle.

Test Plan:
- Reset release, RESET_HOLD=2, run_en=1: core_reset high 2 cycles after reset falls; then phase_en sequences 0001,0010,0100,1000,0001…; instr_done only with 1000.
- 10 full instructions in RUN: instr_count=10, cycle_count=40; halt_req raised in phase 1 → phase 2 and 3 complete, halted=1 next cycle, instr_count=11.
- In HALT, a single step_req pulse: exactly 4 strobes, instr_count +1, halted re-asserts. A second pulse during STEP is ignored (count +1 only).
- HALT with run_en=1 and step_req edge in the same cycle: enters RUN, no extra STEP afterwards. halt_req=1 with step edge: remains HALT.
- reset asserted in phase 2: next edge gives phase_en=0, counters=0, core_reset=1, state RESET.
- PROC_PHASE_STALL_EN, mem_stall high 3 cycles in phase 2: phase_en=0100 for 4 cycles; cycle_count per instruction = 7, instr_count +1.

Source files
------------

// File: rtl/proc_phase_sequencer.sv
// proc_phase_sequencer
// Single-clock phase/strobe sequencer for the multicycle MIPS core.
// Produces one-hot phase enables (fetch, regfile read, ALU/dmem,
// writeback/PC update) in place of per-unit derived clocks, plus a
// stretched core reset, run/halt/single-step control and saturating
// cycle/instruction counters.
//
// Optional build macro: PROC_PHASE_STALL_EN
//   When defined, adds parameter STALL_PHASE and input mem_stall. While the
//   sequencer sits in STALL_PHASE with mem_stall high, the phase holds and
//   its strobe repeats every cycle.
//
// Handshake/control semantics: run_en and halt_req are levels; step_req is
// edge-triggered (0->1 sampled on the clock) and only acted on in HALT;
// halt and stop requests are only honoured at an instruction boundary.
module proc_phase_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int PH_W       = 2,
    parameter int RESET_HOLD = 2,
    parameter int CYC_W      = 32
`ifdef PROC_PHASE_STALL_EN
    ,
    parameter int STALL_PHASE = 2
`endif
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run_en,
    input  logic                  step_req,
    input  logic                  halt_req,
`ifdef PROC_PHASE_STALL_EN
    input  logic                  mem_stall,
`endif
    output logic [NUM_PHASES-1:0] phase_en,
    output logic [PH_W-1:0]       phase_idx,
    output logic                  instr_done,
    output logic                  core_reset,
    output logic                  halted,
    output logic [CYC_W-1:0]      cycle_count,
    output logic [CYC_W-1:0]      instr_count
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_STEP  = 2'd3
    } state_t;

    // Hold counter is wide enough to count up to RESET_HOLD.
    localparam int HOLD_W = $clog2(RESET_HOLD + 2);
    // RESET exits on the edge where the counter equals this value; a hold of
    // zero still needs one edge after reset drops.
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (RESET_HOLD == 0) ? '0 : HOLD_W'(RESET_HOLD - 1);
    localparam logic [PH_W-1:0]       LAST_PH   = PH_W'(NUM_PHASES - 1);
    localparam logic [NUM_PHASES-1:0] FIRST_STB = NUM_PHASES'(1);

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              step_q;
    logic              step_edge;
    logic              stall_now;
    logic              at_boundary;

    assign step_edge   = step_req & ~step_q;
    assign at_boundary = (phase_idx == LAST_PH);

`ifdef PROC_PHASE_STALL_EN
    assign stall_now = mem_stall && (phase_idx == PH_W'(STALL_PHASE));
`else
    assign stall_now = 1'b0;
`endif

    // Sequencer FSM: state plus all registered control outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_RESET;
            hold_cnt   <= '0;
            step_q     <= 1'b0;
            phase_en   <= '0;
            phase_idx  <= '0;
            instr_done <= 1'b0;
            core_reset <= 1'b1;
            halted     <= 1'b0;
        end else begin
            // Edge detector runs in every state; edges seen outside HALT are
            // simply consumed and never remembered.
            step_q <= step_req;
            case (state)
                ST_RESET: begin
                    if (hold_cnt == HOLD_LAST) begin
                        core_reset <= 1'b0;
                        phase_idx  <= '0;
                        instr_done <= 1'b0;
                        if (run_en && !halt_req) begin
                            state    <= ST_RUN;
                            phase_en <= FIRST_STB;
                            halted   <= 1'b0;
                        end else begin
                            state    <= ST_HALT;
                            phase_en <= '0;
                            halted   <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                ST_RUN, ST_STEP: begin
                    if (stall_now) begin
                        // Memory stall: hold phase, strobe and done as they are.
                        state <= state;
                    end else if (at_boundary) begin
                        if (state == ST_STEP || halt_req || !run_en) begin
                            state      <= ST_HALT;
                            phase_en   <= '0;
                            phase_idx  <= '0;
                            instr_done <= 1'b0;
                            halted     <= 1'b1;
                        end else begin
                            phase_en   <= FIRST_STB;
                            phase_idx  <= '0;
                            instr_done <= 1'b0;
                        end
                    end else begin
                        phase_en   <= phase_en << 1;
                        phase_idx  <= phase_idx + 1'b1;
                        instr_done <= ((phase_idx + 1'b1) == LAST_PH);
                    end
                end

                ST_HALT: begin
                    // Run has priority; a step edge in the same cycle is lost.
                    if (run_en && !halt_req) begin
                        state      <= ST_RUN;
                        phase_en   <= FIRST_STB;
                        phase_idx  <= '0;
                        instr_done <= 1'b0;
                        halted     <= 1'b0;
                    end else if (step_edge && !halt_req) begin
                        state      <= ST_STEP;
                        phase_en   <= FIRST_STB;
                        phase_idx  <= '0;
                        instr_done <= 1'b0;
                        halted     <= 1'b0;
                    end else begin
                        phase_en   <= '0;
                        phase_idx  <= '0;
                        instr_done <= 1'b0;
                        halted     <= 1'b1;
                    end
                end

                default: begin
                    state      <= ST_RESET;
                    hold_cnt   <= '0;
                    phase_en   <= '0;
                    phase_idx  <= '0;
                    instr_done <= 1'b0;
                    core_reset <= 1'b1;
                    halted     <= 1'b0;
                end
            endcase
        end
    end

    // Saturating counters of active cycles and completed instructions.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if ((phase_en != '0) && (cycle_count != '1)) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (instr_done && (instr_count != '1)) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_proc_phase_sequencer.sv
// Bench for proc_phase_sequencer: abstract behavioural model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
// Counters are built 6 bits wide so saturation is reachable.
module tb_proc_phase_sequencer;

    localparam int N     = 4;
    localparam int PH_W  = 2;
    localparam int HOLD  = 2;
    localparam int CYC_W = 6;
    localparam int SP    = 2;
    localparam int SAT   = (1 << CYC_W) - 1;
    localparam int EXIT_AFTER = (HOLD < 1) ? 1 : HOLD;

    localparam int M_RESET = 0;
    localparam int M_RUN   = 1;
    localparam int M_HALT  = 2;
    localparam int M_STEP  = 3;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             run_en = 1'b0;
    logic             step_req = 1'b0;
    logic             halt_req = 1'b0;
    logic             mem_stall = 1'b0;
    logic [N-1:0]     phase_en;
    logic [PH_W-1:0]  phase_idx;
    logic             instr_done;
    logic             core_reset;
    logic             halted;
    logic [CYC_W-1:0] cycle_count;
    logic [CYC_W-1:0] instr_count;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    proc_phase_sequencer #(
        .NUM_PHASES (N),
        .PH_W       (PH_W),
        .RESET_HOLD (HOLD),
        .CYC_W      (CYC_W)
`ifdef PROC_PHASE_STALL_EN
        ,
        .STALL_PHASE(SP)
`endif
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .run_en     (run_en),
        .step_req   (step_req),
        .halt_req   (halt_req),
`ifdef PROC_PHASE_STALL_EN
        .mem_stall  (mem_stall),
`endif
        .phase_en   (phase_en),
        .phase_idx  (phase_idx),
        .instr_done (instr_done),
        .core_reset (core_reset),
        .halted     (halted),
        .cycle_count(cycle_count),
        .instr_count(instr_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Abstract state: mode, position within the instruction, reset hold
    // progress, and the two counts.
    int m_mode = M_RESET;
    int m_pos = 0;
    int m_hold = 0;
    int m_cycles = 0;
    int m_instrs = 0;
    bit m_prev_step = 1'b0;
    bit m_valid = 1'b0;

    always @(posedge clock) begin : model
        bit edge_seen;
        bit active;
        bit stall;
        edge_seen   = step_req && !m_prev_step;
        m_prev_step = step_req;
        active      = (m_mode == M_RUN) || (m_mode == M_STEP);
`ifdef PROC_PHASE_STALL_EN
        stall = active && mem_stall && (m_pos == SP);
`else
        stall = 1'b0;
`endif
        if (reset) begin
            m_mode = M_RESET; m_pos = 0; m_hold = 0;
            m_cycles = 0; m_instrs = 0; m_prev_step = 1'b0;
            m_valid = 1'b1;
        end else begin
            if (active) m_cycles = (m_cycles >= SAT) ? SAT : m_cycles + 1;
            if (active && m_pos == N - 1) m_instrs = (m_instrs >= SAT) ? SAT : m_instrs + 1;
            case (m_mode)
                M_RESET: begin
                    m_hold++;
                    if (m_hold >= EXIT_AFTER) begin
                        m_pos  = 0;
                        m_mode = (run_en && !halt_req) ? M_RUN : M_HALT;
                    end
                end
                M_RUN, M_STEP: begin
                    if (!stall) begin
                        if (m_pos == N - 1) begin
                            m_pos = 0;
                            if (m_mode == M_STEP || halt_req || !run_en) m_mode = M_HALT;
                        end else begin
                            m_pos++;
                        end
                    end
                end
                default: begin
                    m_pos = 0;
                    if (run_en && !halt_req) m_mode = M_RUN;
                    else if (edge_seen && !halt_req) m_mode = M_STEP;
                end
            endcase
        end
    end

    // ---------------- scoreboard compare (every cycle) ----------------
    always @(negedge clock) begin : compare
        bit active;
        if (m_valid) begin
            active = (m_mode == M_RUN) || (m_mode == M_STEP);
            check("phase_en",    64'(phase_en),    active ? 64'(1) << m_pos : 64'd0);
            check("phase_idx",   64'(phase_idx),   active ? 64'(m_pos) : 64'd0);
            check("instr_done",  64'(instr_done),  64'(active && m_pos == N - 1));
            check("core_reset",  64'(core_reset),  64'(m_mode == M_RESET));
            check("halted",      64'(halted),      64'(m_mode == M_HALT));
            check("cycle_count", 64'(cycle_count), 64'(m_cycles));
            check("instr_count", 64'(instr_count), 64'(m_instrs));
        end
    end

    // ---------------- driver ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin : driver
        int strobes;
        tick(3);
        check("lit_rst_phase_en", 64'(phase_en), 64'd0);
        check("lit_rst_core_reset", 64'(core_reset), 64'd1);
        check("lit_rst_counts", 64'({cycle_count, instr_count}), 64'd0);
        check("lit_rst_halted", 64'(halted), 64'd0);

        // Reset release with run_en high: two cycles of core_reset, then run.
        #1 reset = 1'b0; run_en = 1'b1;
        tick(1);
        check("lit_hold_core_reset", 64'(core_reset), 64'd1);
        check("lit_hold_phase_en", 64'(phase_en), 64'd0);
        tick(1);
        check("lit_release_core_reset", 64'(core_reset), 64'd0);
        for (int i = 0; i < 40; i++) begin
            check("lit_seq_phase_en", 64'(phase_en), 64'd1 << (i % 4));
            check("lit_seq_instr_done", 64'(instr_done), 64'((i % 4) == 3));
            tick(1);
        end
        check("lit_10instr_cycles", 64'(cycle_count), 64'd40);
        check("lit_10instr_instrs", 64'(instr_count), 64'd10);

        // Halt requested in phase 1: instruction completes, then HALT.
        tick(1);
        check("lit_halt_ph1", 64'(phase_en), 64'h2);
        #1 halt_req = 1'b1;
        tick(1);
        check("lit_halt_ph2", 64'(phase_en), 64'h4);
        tick(1);
        check("lit_halt_ph3", 64'(phase_en), 64'h8);
        tick(1);
        check("lit_halted", 64'(halted), 64'd1);
        check("lit_halted_phase_en", 64'(phase_en), 64'd0);
        check("lit_halted_instrs", 64'(instr_count), 64'd11);
        check("lit_halted_cycles", 64'(cycle_count), 64'd44);
        #1 halt_req = 1'b0; run_en = 1'b0;
        tick(2);
        check("lit_stay_halted", 64'(halted), 64'd1);

        // Single step, with a second pulse during STEP that must be dropped.
        #1 step_req = 1'b1;
        strobes = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            if (phase_en != '0) strobes++;
            if (i == 1) #1 step_req = 1'b0;
            if (i == 2) #1 step_req = 1'b1;
            if (i == 3) #1 step_req = 1'b0;
        end
        check("lit_step_strobes", 64'(strobes), 64'd4);
        check("lit_step_halted", 64'(halted), 64'd1);
        check("lit_step_instrs", 64'(instr_count), 64'd12);

        // Run and step edge together: run wins, no trailing STEP.
        #1 run_en = 1'b1; step_req = 1'b1;
        tick(1);
        check("lit_runstep_ph0", 64'(phase_en), 64'h1);
        #1 run_en = 1'b0;
        tick(3);
        check("lit_runstep_ph3", 64'(phase_en), 64'h8);
        tick(1);
        check("lit_runstep_halted", 64'(halted), 64'd1);
        check("lit_runstep_instrs", 64'(instr_count), 64'd13);
        tick(3);
        check("lit_runstep_no_step", 64'(phase_en), 64'd0);
        #1 step_req = 1'b0;

        // halt_req suppresses a step edge.
        tick(1);
        #1 halt_req = 1'b1; step_req = 1'b1;
        tick(3);
        check("lit_haltstep_halted", 64'(halted), 64'd1);
        check("lit_haltstep_phase_en", 64'(phase_en), 64'd0);
        #1 halt_req = 1'b0; step_req = 1'b0;
        tick(1);
        check("lit_haltstep_after", 64'(halted), 64'd1);

        // Run long enough to saturate the 6-bit cycle counter.
        #1 run_en = 1'b1;
        tick(1);
        check("lit_sat_start", 64'(cycle_count), 64'd52);
        tick(20);
        check("lit_sat_cycles", 64'(cycle_count), 64'd63);
        check("lit_sat_instrs", 64'(instr_count), 64'd18);

        // Reset in phase 2 aborts the instruction.
        tick(2);
        check("lit_mid_ph2", 64'(phase_en), 64'h4);
        #1 reset = 1'b1;
        tick(1);
        check("lit_mid_phase_en", 64'(phase_en), 64'd0);
        check("lit_mid_core_reset", 64'(core_reset), 64'd1);
        check("lit_mid_counts", 64'({cycle_count, instr_count}), 64'd0);
        check("lit_mid_done", 64'(instr_done), 64'd0);

        // Restart and (if built) stall three cycles in phase 2.
        #1 reset = 1'b0;
        tick(2);
        check("lit_restart_ph0", 64'(phase_en), 64'h1);
        tick(2);
        check("lit_restart_ph2", 64'(phase_en), 64'h4);
`ifdef PROC_PHASE_STALL_EN
        #1 mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("lit_stall_hold", 64'(phase_en), 64'h4);
        end
        #1 mem_stall = 1'b0;
        tick(1);
        check("lit_stall_ph3", 64'(phase_en), 64'h8);
        tick(1);
        check("lit_stall_cycles", 64'(cycle_count), 64'd7);
`else
        tick(1);
        check("lit_nostall_ph3", 64'(phase_en), 64'h8);
        tick(1);
        check("lit_nostall_cycles", 64'(cycle_count), 64'd4);
`endif
        check("lit_restart_instrs", 64'(instr_count), 64'd1);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
